// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DEPTH = 8;

  // Address width for a power-of-two depth; never narrower than one bit.
  function automatic int calcAw(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One registered read port: register select, optional write forwarding,
// output data register and a one-cycle valid flag.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int BYPASS = 1,
  localparam int AW    = calcAw(DEPTH)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         re_i,
  input  logic [AW-1:0]                addr_i,
  input  logic [DEPTH-1:0][WIDTH-1:0]  regs_i,
  input  logic                         we0_i,
  input  logic [AW-1:0]                wa0_i,
  input  logic [WIDTH-1:0]             wd0_i,
  input  logic                         we1_i,
  input  logic [AW-1:0]                wa1_i,
  input  logic [WIDTH-1:0]             wd1_i,
  output logic [WIDTH-1:0]             q_o,
  output logic                         v_o
);

  logic [WIDTH-1:0] rdData;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;
  logic             valid_d;
  logic             valid_q;

  // Pick the addressed register; with forwarding on, a same-cycle write to
  // that address replaces it, port 1 taking priority over port 0. Write
  // enables arrive already qualified, so suppressed writes never forward.
  always_comb begin
    rdData = regs_i[addr_i];
    if (BYPASS != 0) begin
      if (we0_i && (wa0_i == addr_i)) rdData = wd0_i;
      if (we1_i && (wa1_i == addr_i)) rdData = wd1_i;
    end
    data_d  = re_i ? rdData : data_q;
    valid_d = re_i;
  end

  // Output register: reset clears data and discards any in-flight read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q_o = data_q;
  assign v_o = valid_q;

endmodule

// File: rtl/regfile_mp.sv
// Two-write, two-read register file built from flip-flops, with optional
// hard-wired zero register and optional write-to-read forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1,
  localparam int AW      = calcAw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we0,
  input  logic             we1,
  input  logic [AW-1:0]    addre_wr0,
  input  logic [AW-1:0]    addre_wr1,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  input  logic             reA,
  input  logic             reB,
  input  logic [AW-1:0]    addre_rdA,
  input  logic [AW-1:0]    addre_rdB,
  output logic [WIDTH-1:0] QA,
  output logic [WIDTH-1:0] QB,
  output logic             vA,
  output logic             vB
);

  logic [DEPTH-1:0][WIDTH-1:0] regs_d;
  logic [DEPTH-1:0][WIDTH-1:0] regs_q;
  logic                        wen0;
  logic                        wen1;

  // With a zero register, writes to address 0 are dropped here so that both
  // storage and the forwarding path ignore them.
  assign wen0 = we0 && !((ZERO_REG != 0) && (addre_wr0 == '0));
  assign wen1 = we1 && !((ZERO_REG != 0) && (addre_wr1 == '0));

  // Next storage contents; port 1 is applied last so it wins an address clash.
  always_comb begin
    regs_d = regs_q;
    if (wen0) regs_d[addre_wr0] = D0;
    if (wen1) regs_d[addre_wr1] = D1;
  end

  // Storage array, cleared by reset regardless of pending writes.
  always_ff @(posedge clk) begin
    if (rst) regs_q <= '0;
    else     regs_q <= regs_d;
  end

  regfile_rdport #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .BYPASS(BYPASS)
  ) u_rdportA (
    .clk_i (clk),
    .rst_i (rst),
    .re_i  (reA),
    .addr_i(addre_rdA),
    .regs_i(regs_q),
    .we0_i (wen0),
    .wa0_i (addre_wr0),
    .wd0_i (D0),
    .we1_i (wen1),
    .wa1_i (addre_wr1),
    .wd1_i (D1),
    .q_o   (QA),
    .v_o   (vA)
  );

  regfile_rdport #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .BYPASS(BYPASS)
  ) u_rdportB (
    .clk_i (clk),
    .rst_i (rst),
    .re_i  (reB),
    .addr_i(addre_rdB),
    .regs_i(regs_q),
    .we0_i (wen0),
    .wa0_i (addre_wr0),
    .wd0_i (D0),
    .we1_i (wen1),
    .wa1_i (addre_wr1),
    .wd1_i (D1),
    .q_o   (QB),
    .v_o   (vB)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: two instances (16x8 with forwarding, and 32x32
// with zero register and no forwarding) checked against a behavioural model
// through an expected-result queue.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small instance: WIDTH 16, DEPTH 8, ZERO_REG 0, BYPASS 1
  logic        sRst, sWe0, sWe1, sReA, sReB;
  logic [2:0]  sWa0, sWa1, sRaA, sRaB;
  logic [15:0] sD0, sD1, sQA, sQB;
  logic        sVA, sVB;

  // Large instance: WIDTH 32, DEPTH 32, ZERO_REG 1, BYPASS 0
  logic        lRst, lWe0, lWe1, lReA, lReB;
  logic [4:0]  lWa0, lWa1, lRaA, lRaB;
  logic [31:0] lD0, lD1, lQA, lQB;
  logic        lVA, lVB;

  regfile_mp #(.WIDTH(16), .DEPTH(8), .ZERO_REG(0), .BYPASS(1)) dutSmall (
    .clk(clk), .rst(sRst), .we0(sWe0), .we1(sWe1),
    .addre_wr0(sWa0), .addre_wr1(sWa1), .D0(sD0), .D1(sD1),
    .reA(sReA), .reB(sReB), .addre_rdA(sRaA), .addre_rdB(sRaB),
    .QA(sQA), .QB(sQB), .vA(sVA), .vB(sVB)
  );

  regfile_mp #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(0)) dutLarge (
    .clk(clk), .rst(lRst), .we0(lWe0), .we1(lWe1),
    .addre_wr0(lWa0), .addre_wr1(lWa1), .D0(lD0), .D1(lD1),
    .reA(lReA), .reB(lReB), .addre_rdA(lRaA), .addre_rdB(lRaB),
    .QA(lQA), .QB(lQB), .vA(lVA), .vB(lVB)
  );

  typedef struct {
    int          dut;
    logic [63:0] qa;
    logic [63:0] qb;
    logic        va;
    logic        vb;
  } expect_t;

  expect_t     expQueue[$];
  logic [63:0] modelMem [2][64];
  logic [63:0] modelQA [2];
  logic [63:0] modelQB [2];
  int          cfgZero [2] = '{0, 1};
  int          cfgBypass [2] = '{1, 0};
  int          testsRun = 0;
  int          testsFailed = 0;
  string       curTest = "init";

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference read: stored value, replaced by a same-cycle write when the
  // instance forwards writes (port 1 after port 0 so it wins).
  function automatic logic [63:0] modelRead(input int d, input int addr,
                                            input bit wen0, input int wa0, input logic [63:0] d0,
                                            input bit wen1, input int wa1, input logic [63:0] d1);
    logic [63:0] v;
    v = modelMem[d][addr];
    if (cfgBypass[d] != 0) begin
      if (wen0 && (wa0 == addr)) v = d0;
      if (wen1 && (wa1 == addr)) v = d1;
    end
    return v;
  endfunction

  // Pop the oldest expectation and compare it with the instance it targets.
  task automatic popAndCheck();
    expect_t     e;
    logic [63:0] oa, ob, ova, ovb;
    if (expQueue.size() == 0) begin
      $display("[TB] FAIL scoreboard: got empty queue, expected one entry");
      $fatal(1, "[TB] scoreboard underflow");
    end
    e = expQueue.pop_front();
    if (e.dut == 0) begin
      oa = 64'(sQA); ob = 64'(sQB); ova = 64'(sVA); ovb = 64'(sVB);
    end else begin
      oa = 64'(lQA); ob = 64'(lQB); ova = 64'(lVA); ovb = 64'(lVB);
    end
    checkOutput({curTest, " QA"}, oa, e.qa);
    checkOutput({curTest, " vA"}, ova, 64'(e.va));
    checkOutput({curTest, " QB"}, ob, e.qb);
    checkOutput({curTest, " vB"}, ovb, 64'(e.vb));
  endtask

  // Drive one cycle on instance d, push the model's expectation, clock, check.
  task automatic applyStimulus(input int d, input bit rstIn,
                               input bit we0, input int wa0, input logic [63:0] d0,
                               input bit we1, input int wa1, input logic [63:0] d1,
                               input bit reA, input int raA, input bit reB, input int raB);
    expect_t e;
    bit      wen0, wen1;
    if (d == 0) begin
      sRst = rstIn; sWe0 = we0; sWa0 = 3'(wa0); sD0 = d0[15:0];
      sWe1 = we1; sWa1 = 3'(wa1); sD1 = d1[15:0];
      sReA = reA; sRaA = 3'(raA); sReB = reB; sRaB = 3'(raB);
    end else begin
      lRst = rstIn; lWe0 = we0; lWa0 = 5'(wa0); lD0 = d0[31:0];
      lWe1 = we1; lWa1 = 5'(wa1); lD1 = d1[31:0];
      lReA = reA; lRaA = 5'(raA); lReB = reB; lRaB = 5'(raB);
    end
    wen0 = we0 && !((cfgZero[d] != 0) && (wa0 == 0));
    wen1 = we1 && !((cfgZero[d] != 0) && (wa1 == 0));
    if (rstIn) begin
      for (int a = 0; a < 64; a++) modelMem[d][a] = '0;
      modelQA[d] = '0;
      modelQB[d] = '0;
      e.va = 1'b0;
      e.vb = 1'b0;
    end else begin
      if (reA) modelQA[d] = modelRead(d, raA, wen0, wa0, d0, wen1, wa1, d1);
      if (reB) modelQB[d] = modelRead(d, raB, wen0, wa0, d0, wen1, wa1, d1);
      e.va = reA;
      e.vb = reB;
      if (wen0) modelMem[d][wa0] = d0;
      if (wen1) modelMem[d][wa1] = d1;
    end
    e.dut = d;
    e.qa  = modelQA[d];
    e.qb  = modelQB[d];
    expQueue.push_back(e);
    @(posedge clk);
    #1;
    popAndCheck();
    if (d == 0) begin
      sRst = 0; sWe0 = 0; sWe1 = 0; sReA = 0; sReB = 0;
    end else begin
      lRst = 0; lWe0 = 0; lWe1 = 0; lReA = 0; lReB = 0;
    end
  endtask

  initial begin
    sRst = 1; sWe0 = 0; sWe1 = 0; sWa0 = 0; sWa1 = 0; sD0 = 0; sD1 = 0;
    sReA = 0; sReB = 0; sRaA = 0; sRaB = 0;
    lRst = 1; lWe0 = 0; lWe1 = 0; lWa0 = 0; lWa1 = 0; lD0 = 0; lD1 = 0;
    lReA = 0; lReB = 0; lRaA = 0; lRaB = 0;

    // ---------------- small instance ----------------
    curTest = "s_reset";
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2);

    curTest = "s_readAll";
    for (int i = 0; i < 8; i++)
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, i, 1, 7 - i);

    curTest = "s_write3";
    applyStimulus(0, 0, 1, 3, 64'h1234, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0);

    curTest = "s_conflict";
    applyStimulus(0, 0, 1, 5, 64'hAAAA, 1, 5, 64'h5555, 0, 0, 1, 5);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 1, 5);

    curTest = "s_sameAddr";
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 3);

    curTest = "s_bypassP0";
    applyStimulus(0, 0, 1, 6, 64'hC0DE, 1, 1, 64'h0101, 1, 6, 1, 1);

    curTest = "s_idleHold";
    applyStimulus(0, 0, 1, 7, 64'h7E7E, 0, 0, 0, 0, 0, 0, 0);

    curTest = "s_random";
    for (int i = 0; i < 40; i++)
      applyStimulus(0, ($urandom_range(0, 19) == 0),
                    1'($urandom_range(0, 1)), $urandom_range(0, 7), 64'($urandom_range(0, 65535)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 7), 64'($urandom_range(0, 65535)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 7),
                    1'($urandom_range(0, 1)), $urandom_range(0, 7));

    curTest = "s_midReset";
    applyStimulus(0, 0, 1, 2, 64'h2222, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 3);
    applyStimulus(0, 1, 1, 2, 64'h7777, 0, 0, 0, 1, 2, 1, 3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 3);

    // ---------------- large instance ----------------
    curTest = "l_reset";
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    curTest = "l_firstCycle";
    applyStimulus(1, 0, 1, 9, 64'h9999_0000, 0, 0, 0, 1, 31, 1, 9);

    curTest = "l_noBypass";
    applyStimulus(1, 0, 1, 2, 64'h0F0F, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 2, 64'hFFFF, 0, 0, 0, 1, 2, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 9);

    curTest = "l_zeroReg";
    applyStimulus(1, 0, 1, 0, 64'hBEEF, 1, 0, 64'h1111, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);

    curTest = "l_wideReset";
    applyStimulus(1, 0, 1, 31, 64'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 31, 1, 31);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 1, 31, 1, 31);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 31, 0, 0);

    curTest = "l_random";
    for (int i = 0; i < 40; i++)
      applyStimulus(1, ($urandom_range(0, 19) == 0),
                    1'($urandom_range(0, 1)), $urandom_range(0, 31), 64'($urandom),
                    1'($urandom_range(0, 1)), $urandom_range(0, 31), 64'($urandom),
                    1'($urandom_range(0, 1)), $urandom_range(0, 31),
                    1'($urandom_range(0, 1)), $urandom_range(0, 31));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
